// File: rtl/pipeline_if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
interface pipeline_if_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: PC sequencing, memory handshake, redirect and registered output to ID.
// Optional one-entry skid buffer enabled by defining IF_SKID_BUF_EN.
module pipeline_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  pipeline_if_stage_if.master  imem,
  output logic [31:0]          instruction_IF,
  output logic [63:0]          pc_IF,
  output logic                 valid_IF
);

`ifdef IF_SKID_BUF_EN
  typedef enum logic [1:0] {BOOT, FETCH, BUF} state_t;
`else
  typedef enum logic {BOOT, FETCH} state_t;
`endif

  state_t      state, state_nx;
  logic [63:0] pc_p0, pc_nx;
  logic [31:0] inst_nx;
  logic [63:0] pcif_nx;
  logic        vld_nx;
  logic        accept;

`ifdef IF_SKID_BUF_EN
  logic [31:0] buf_inst_p1;
  logic [63:0] buf_pc_p1;
  logic        buf_load;
`endif

  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

  assign imem.imem_addr = pc_p0;
  assign accept         = imem.imem_req & imem.imem_ready;

  // Request is withheld during reset so nothing is fetched before BOOT.
  always_comb begin
    imem.imem_req = 1'b0;
    if (!reset && state == FETCH) begin
`ifdef IF_SKID_BUF_EN
      imem.imem_req = 1'b1;
`else
      imem.imem_req = ~stall;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_p0;
    inst_nx  = instruction_IF;
    pcif_nx  = pc_IF;
    vld_nx   = valid_IF;
`ifdef IF_SKID_BUF_EN
    buf_load = 1'b0;
`endif
    if (redirect_valid) begin
      pc_nx    = align_pc(redirect_pc);
      vld_nx   = 1'b0;
      inst_nx  = NOP_INST;
      state_nx = FETCH;
    end
`ifdef IF_SKID_BUF_EN
    else if (state == BUF) begin
      if (!stall) begin
        inst_nx  = buf_inst_p1;
        pcif_nx  = buf_pc_p1;
        vld_nx   = 1'b1;
        state_nx = FETCH;
      end
    end
`endif
    else begin
      if (state == BOOT) state_nx = FETCH;
      if (!stall) begin
        if (accept) begin
          inst_nx = imem.imem_rdata;
          pcif_nx = pc_p0;
          vld_nx  = 1'b1;
          pc_nx   = pc_p0 + 64'd4;
        end else begin
          inst_nx = NOP_INST;
          vld_nx  = 1'b0;
        end
      end
`ifdef IF_SKID_BUF_EN
      else if (accept) begin
        buf_load = 1'b1;
        pc_nx    = pc_p0 + 64'd4;
        state_nx = BUF;
      end
`endif
    end
  end

  // Fetch PC and IF/ID output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      pc_p0          <= RESET_PC;
      valid_IF       <= 1'b0;
      instruction_IF <= NOP_INST;
      pc_IF          <= 64'h0;
    end else begin
      state          <= state_nx;
      pc_p0          <= pc_nx;
      valid_IF       <= vld_nx;
      instruction_IF <= inst_nx;
      pc_IF          <= pcif_nx;
    end
  end

`ifdef IF_SKID_BUF_EN
  // Skid buffer payload; occupancy is tracked by the BUF state alone
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_inst_p1 <= imem.imem_rdata;
      buf_pc_p1   <= pc_p0;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Self-checking bench for pipeline_if_stage: directed scenarios plus randomized traffic vs. a rule-level model.
module tb_pipeline_if_stage;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IF;
  logic        valid_IF;

  pipeline_if_stage_if bus ();

  pipeline_if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(bus.master),
    .instruction_IF(instruction_IF), .pc_IF(pc_IF), .valid_IF(valid_IF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: 0 = boot, 1 = fetch, 2 = holding a buffered instruction
  int          m_st = 0;
  logic [63:0] m_pc = 64'h0, m_pcif = 64'h0, m_bpc = 64'h0;
  logic [31:0] m_inst = NOP, m_binst = 32'h0;
  logic        m_vld = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_req(input logic r, input logic s);
    if (r || m_st != 1) return 1'b0;
`ifdef IF_SKID_BUF_EN
    return 1'b1;
`else
    return ~s;
`endif
  endfunction

  task automatic model_step(input logic r, input logic s, input logic rv,
                            input logic [63:0] rpc, input logic rdy, input logic [31:0] d);
    logic acc;
    acc = model_req(r, s) && rdy;
    if (r) begin
      m_pc = RPC; m_st = 0; m_vld = 1'b0; m_inst = NOP; m_pcif = 64'h0;
    end else if (rv) begin
      m_pc = {rpc[63:2], 2'b00}; m_vld = 1'b0; m_inst = NOP; m_st = 1;
    end else if (m_st == 2) begin
      if (!s) begin
        m_inst = m_binst; m_pcif = m_bpc; m_vld = 1'b1; m_st = 1;
      end
    end else begin
      if (!s && acc) begin
        m_inst = d; m_pcif = m_pc; m_vld = 1'b1; m_pc = m_pc + 64'd4;
      end else if (!s) begin
        m_inst = NOP; m_vld = 1'b0;
      end else if (acc) begin
        m_binst = d; m_bpc = m_pc; m_pc = m_pc + 64'd4; m_st = 2;
      end
      if (m_st == 0) m_st = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic rv,
                       input logic [63:0] rpc, input logic rdy);
    logic [31:0] d;
    @(negedge clk);
    d = $urandom;
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    bus.imem_ready = rdy; bus.imem_rdata = d;
    #1;
    chk("imem_req", {63'h0, bus.imem_req}, {63'h0, model_req(r, s)});
    if (!r) chk("imem_addr", bus.imem_addr, m_pc);
    model_step(r, s, rv, rpc, rdy, d);
    @(posedge clk);
    #1;
    chk("valid_IF", {63'h0, valid_IF}, {63'h0, m_vld});
    chk("instruction_IF", {32'h0, instruction_IF}, {32'h0, m_inst});
    chk("pc_IF", pc_IF, m_pcif);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;

    // Reset, boot bubble, then back-to-back fetch
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("rst_valid", {63'h0, valid_IF}, 64'h0);
    chk("rst_inst", {32'h0, instruction_IF}, {32'h0, NOP});
    chk("rst_pc_IF", pc_IF, 64'h0);
    cycle(0, 0, 0, 0, 1);
    chk("boot_valid", {63'h0, valid_IF}, 64'h0);
    cycle(0, 0, 0, 0, 1); chk("seq_pc0", pc_IF, 64'h1000);
    cycle(0, 0, 0, 0, 1); chk("seq_pc1", pc_IF, 64'h1004);
    cycle(0, 0, 0, 0, 1); chk("seq_pc2", pc_IF, 64'h1008);

    // Stall freezes outputs, release continues at next PC
    cycle(0, 1, 0, 0, 1); chk("stall_pc_a", pc_IF, 64'h1008);
    cycle(0, 1, 0, 0, 1); chk("stall_pc_b", pc_IF, 64'h1008);
    chk("stall_valid", {63'h0, valid_IF}, 64'h1);
    cycle(0, 0, 0, 0, 1); chk("release_pc", pc_IF, 64'h100C);

    // Redirect beats stall and same-cycle accept; low bits dropped
    cycle(0, 1, 1, 64'h3003, 1);
    chk("redir_valid", {63'h0, valid_IF}, 64'h0);
    chk("redir_addr", bus.imem_addr, 64'h3000);
    cycle(0, 0, 0, 0, 1); chk("redir_pc_IF", pc_IF, 64'h3000);

    // Wait states give bubbles, then a single copy of the fetched PC
    cycle(0, 0, 1, 64'h2000, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("wait_valid", {63'h0, valid_IF}, 64'h0);
      chk("wait_inst", {32'h0, instruction_IF}, {32'h0, NOP});
    end
    cycle(0, 0, 0, 0, 1); chk("wait_pc_a", pc_IF, 64'h2000);
    cycle(0, 0, 0, 0, 1); chk("wait_pc_b", pc_IF, 64'h2004);

    // PC wraps modulo 2^64
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_pc_IF", pc_IF, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", bus.imem_addr, 64'h0);

    // Reset during a wait state abandons the fetch
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("rst_wait_valid", {63'h0, valid_IF}, 64'h0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1); chk("rst_wait_pc", pc_IF, RPC);

`ifdef IF_SKID_BUF_EN
    // Buffered instruction is dropped by reset
    cycle(0, 0, 1, 64'h4000, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("buf_rst_valid", {63'h0, valid_IF}, 64'h0);
    cycle(0, 0, 0, 0, 1);
    chk("buf_boot_valid", {63'h0, valid_IF}, 64'h0);
    cycle(0, 0, 0, 0, 1); chk("buf_rst_pc", pc_IF, RPC);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, s, rv, rdy;
      logic [63:0] rpc;
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = {$urandom, $urandom};
      cycle(r, s, rv, rpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_if_stage.md
PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC fetched first after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter NOP_INST, default 32'h00000013, is the bubble value driven on instruction_IF when valid_IF=0.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  ID stage cannot accept; IF SHALL hold its outputs.
REQ-006 redirect_valid  input  1  branch/jump taken; redirect_pc SHALL replace the PC.
REQ-007 redirect_pc  input  64  redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  64  fetch address, SHALL equal the internal PC.
REQ-010 imem_ready  input  1  memory accepts and returns data in the same cycle; wait states = cycles with imem_req=1, imem_ready=0.
REQ-011 imem_rdata  input  32  instruction, SHALL be sampled only when imem_req & imem_ready.
REQ-012 instruction_IF  output  32  registered instruction to ID.
REQ-013 pc_IF  output  64  registered PC of instruction_IF.
REQ-014 valid_IF  output  1  instruction_IF/pc_IF hold a real instruction.

Function
REQ-015 State machine SHALL have states BOOT, FETCH, BUF (BUF exists only per REQ-031).
REQ-016 BOOT: imem_req=0; next state FETCH unconditionally (one dead cycle after reset).
REQ-017 FETCH: imem_req=1, except imem_req=0 while stall=1 when REQ-032 applies; memory is stateless, so withdrawal of imem_req is legal.
REQ-018 Accept = imem_req & imem_ready; on accept with stall=0: instruction_IF<=imem_rdata, pc_IF<=PC, valid_IF<=1, PC<=PC+4.
REQ-019 Cycle with stall=0 and no accept (wait state) SHALL load bubble: valid_IF<=0, instruction_IF<=NOP_INST; pc_IF unchanged.
REQ-020 stall=1 and redirect_valid=0: instruction_IF, pc_IF, valid_IF SHALL hold their values.
REQ-021 PC arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-022 redirect_valid=1 SHALL have priority over stall and over any same-cycle accept: PC<={redirect_pc[63:2],2'b00}, valid_IF<=0, instruction_IF<=NOP_INST, accepted data discarded, buffer cleared, state<=FETCH.
REQ-023 Throughput SHALL be one instruction per cycle with imem_ready=1 and stall=0; latency imem_addr -> instruction_IF is one cycle.
REQ-024 In BOOT, redirect_valid SHALL still take effect per REQ-022.

Reset
REQ-025 reset=1 at a rising edge SHALL set PC<=RESET_PC, state<=BOOT, valid_IF<=0, instruction_IF<=NOP_INST, pc_IF<=0, buffer empty.
REQ-026 reset SHALL override redirect_valid, stall and any accept in the same cycle.
REQ-027 Reset asserted mid-wait-state SHALL abandon the pending fetch; no data from that fetch SHALL reach instruction_IF.
REQ-028 imem_req SHALL be 0 during and in the first cycle after reset.

Configuration
REQ-029 Macro IF_SKID_BUF_EN selects a one-entry fetch buffer.
REQ-030 Buffer holds {inst[31:0], pc[63:0]}; full only in state BUF.
REQ-031 Defined: in FETCH, imem_req=1 regardless of stall; accept with stall=1 SHALL store the instruction in the buffer, PC<=PC+4, state<=BUF; BUF: imem_req=0; when stall=0, buffer SHALL move to outputs (valid_IF<=1), state<=FETCH.
REQ-032 Undefined: no buffer, no BUF state; imem_req=0 whenever stall=1 or state=BOOT.
REQ-033 Architectural instruction order and PC sequence SHALL be identical with and without the macro.

Verification
REQ-034 reset 2 cycles, RESET_PC=0x1000, imem_ready=1 -> imem_req=0 in first cycle, then valid_IF pc_IF=0x1000,0x1004,0x1008 on consecutive cycles.
REQ-035 imem_ready low 3 cycles at PC=0x2000 -> valid_IF=0, instruction_IF=0x00000013 for 3 cycles, then pc_IF=0x2000 once, no duplicate.
REQ-036 stall=1 for 2 cycles while pc_IF=0x1008 -> outputs frozen; after release next pc_IF=0x100C (both macro settings).
REQ-037 redirect_valid=1, redirect_pc=0x3003, same cycle stall=1 and accept -> next cycle valid_IF=0, imem_addr=0x3000; following cycle pc_IF=0x3000.
REQ-038 PC=0xFFFF_FFFF_FFFF_FFFC, imem_ready=1 -> next imem_addr=0x0.
REQ-039 IF_SKID_BUF_EN, accept with stall=1 at PC=0x4000 then reset -> valid_IF=0, BOOT, buffered 0x4000 never emitted.
